hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline interlock for the 5-stage DLX core.
- Replaces the tied-off `stall` with generated control. Detects load-use hazards and decode-stage branch/jump-register hazards that the forwarding units cannot cover.
- Sequences multi-cycle EX operations (integer mult/div) with a latency counter.
- Drives freeze/bubble controls into the Fetch, Decode, Execute and Memory stage registers.

Parameters:
- ADDR_W, 6, register address width (0-31 integer, 32-63 FP).
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 2-15.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dec_rs1  in  ADDR_W  source 1 of the instruction in Decode.
- dec_rs2  in  ADDR_W  source 2 of the instruction in Decode.
- dec_uses_rs1  in  1  Decode instruction reads rs1.
- dec_uses_rs2  in  1  Decode instruction reads rs2.
- dec_is_branch  in  1  Decode instruction resolves in Decode using rs1 (beqz/bnez/jr/jalr).
- exe_rd  in  ADDR_W  destination of the instruction in EX.
- exe_reg_we  in  1  EX instruction writes a register.
- exe_is_load  in  1  EX instruction is a load.
- exe_mc_start  in  1  EX holds a multi-cycle op; level, stays high while the op is held.
- mem_rd  in  ADDR_W  destination of the instruction in MEM.
- mem_reg_we  in  1  MEM instruction writes a register.
- mem_is_load  in  1  MEM instruction is a load.
- stall  out  1  freeze the PC and the IF/ID register.
- exe_bubble  out  1  EX latches a NOP (clear RegWE/MEMWE).
- exe_hold  out  1  EX register holds its contents.
- mem_bubble  out  1  MEM latches a NOP.
- busy  out  1  multi-cycle sequencer active.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Register match: match(a,b) = (a==b) && (a!=0). r0 never creates a hazard.
- Load-use hazard:
  - exe_is_load && exe_reg_we && (dec_uses_rs1 && match(dec_rs1,exe_rd) || dec_uses_rs2 && match(dec_rs2,exe_rd)).
- Branch hazard:
  - dec_is_branch && dec_uses_rs1 && (exe_reg_we && match(dec_rs1,exe_rd) || mem_is_load && mem_reg_we && match(dec_rs1,mem_rd)).
  - Branch after a load therefore stalls 2 cycles; after an ALU op, 1 cycle.
- hz = load-use || branch hazard. Combinational, no latency.
- State machine: IDLE, MC_BUSY; 4-bit counter cnt.
  - IDLE, exe_mc_start=1: exe_hold=1; next state MC_BUSY, cnt <= MC_LATENCY-2.
    - If MC_LATENCY==2, cnt=0, so the op completes in the next cycle.
  - IDLE, exe_mc_start=0: exe_hold=0.
  - MC_BUSY, cnt!=0: exe_hold=1; cnt decrements.
  - MC_BUSY, cnt==0: exe_hold=0; next state IDLE. The op leaves EX at the end of this cycle.
  - exe_mc_start is ignored in MC_BUSY. A new multi-cycle op can start the cycle after the return to IDLE.
  - Result: the op spends exactly MC_LATENCY cycles in EX with MC_LATENCY-1 hold cycles.
- Output equations:
  - stall = exe_hold || hz.
  - exe_bubble = hz && !exe_hold. Never kill a held op.
  - mem_bubble = exe_hold.
  - busy = (state==MC_BUSY).
- Simultaneous events: when exe_hold=1, hz is masked from exe_bubble but stall stays 1. In the final MC_BUSY cycle, hz evaluates normally against the completing op's exe_rd.
- Reset: synchronous, highest priority.
  - state=IDLE, cnt=0, stall_count=0.
  - All combinational outputs follow 0 given reset-cleared pipeline inputs.
  - Reset mid-sequence aborts to IDLE; busy=0 the cycle after reset is sampled.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined: stall_count increments by 1 on every clock where stall=1 and reset=0, and saturates at all-ones.
- Undefined: counter logic is removed and stall_count is tied to 0.

Test Plan:
- lw r3,0(r1) in EX, add r4,r3,r5 in Decode -> 1 cycle with stall=1, exe_bubble=1; next cycle stall=0.
- lw r0 in EX, Decode reads r0 -> stall=0, exe_bubble=0.
- beqz r2 in Decode:
  - with add r2 in EX -> stall=1 for 1 cycle.
  - with lw r2 in EX -> stall=1 for 2 cycles (EX hit, then MEM-load hit).
- exe_mc_start held high with MC_LATENCY=4 -> exe_hold=1 for cycles 0-2, 0 in cycle 3; busy=1 cycles 1-3; mem_bubble mirrors exe_hold; exe_bubble=0 throughout, even with a load-use pattern present.
- Reset asserted in cycle 1 of a multi-cycle op -> next cycle state IDLE, busy=0, exe_hold=0 (exe_mc_start low), stall_count=0.
- STALL_PERF_EN defined, CNT_W=4, stall held 20 cycles -> stall_count reads 15 and holds. With the macro undefined -> stall_count reads 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - DLX pipeline interlock: hazard detection, multi-cycle EX sequencing, stall counter
//
// Purpose:
//   Generates the freeze/bubble controls for the IF/ID, ID/EX and EX/MEM
//   stage registers. Detects load-use hazards and Decode-stage branch/jr
//   operand hazards that forwarding cannot cover, and holds a multi-cycle
//   EX operation (mult/div) in EX for MC_LATENCY cycles.
//
// Optional feature:
//   STALL_PERF_EN - when defined, stall_count is a saturating count of
//                   stall cycles; when undefined, stall_count is tied to 0.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   dec_rs1/dec_rs2               Decode source registers
//   dec_uses_rs1/dec_uses_rs2     Decode instruction reads rs1/rs2
//   dec_is_branch                 Decode instruction resolves in Decode on rs1
//   exe_rd/exe_reg_we/exe_is_load EX destination, write enable, load flag
//   exe_mc_start                  EX holds a multi-cycle op (level)
//   mem_rd/mem_reg_we/mem_is_load MEM destination, write enable, load flag
//   stall                         freeze PC and IF/ID
//   exe_bubble                    EX latches a NOP
//   exe_hold                      EX register keeps its contents
//   mem_bubble                    MEM latches a NOP
//   busy                          multi-cycle sequencer active
//   stall_count                   saturating stall-cycle count

module hazard_stall_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic              dec_uses_rs1,
    input  logic              dec_uses_rs2,
    input  logic              dec_is_branch,
    input  logic [ADDR_W-1:0] exe_rd,
    input  logic              exe_reg_we,
    input  logic              exe_is_load,
    input  logic              exe_mc_start,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic              mem_is_load,
    output logic              stall,
    output logic              exe_bubble,
    output logic              exe_hold,
    output logic              mem_bubble,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MC_BUSY = 1'b1
    } state_t;

    // The first EX cycle is spent in IDLE, the last one with cnt==0, so the
    // counter is loaded with the number of cycles in between.
    localparam logic [3:0] LP_CNT_INIT = 4'(MC_LATENCY - 2);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_rs1_exe_match;
    logic w_rs2_exe_match;
    logic w_rs1_mem_match;
    logic w_load_use;
    logic w_branch_hz;
    logic w_hz;
    logic w_exe_hold;
    logic w_stall;

    // Register r0 is hard-wired to zero and never creates a dependency.
    assign w_rs1_exe_match = (dec_rs1 == exe_rd) && (dec_rs1 != '0);
    assign w_rs2_exe_match = (dec_rs2 == exe_rd) && (dec_rs2 != '0);
    assign w_rs1_mem_match = (dec_rs1 == mem_rd) && (dec_rs1 != '0);

    assign w_load_use = exe_is_load && exe_reg_we &&
                        ((dec_uses_rs1 && w_rs1_exe_match) ||
                         (dec_uses_rs2 && w_rs2_exe_match));

    // Branches compare in Decode, so any EX producer is too late, and a
    // load in MEM has no data yet either.
    assign w_branch_hz = dec_is_branch && dec_uses_rs1 &&
                         ((exe_reg_we && w_rs1_exe_match) ||
                          (mem_is_load && mem_reg_we && w_rs1_mem_match));

    assign w_hz = w_load_use || w_branch_hz;

    // In IDLE the hold follows exe_mc_start directly so the op is frozen in
    // its first EX cycle; in MC_BUSY the last cycle (cnt==0) releases it.
    assign w_exe_hold = (r_state == S_IDLE) ? exe_mc_start : (r_cnt != 4'd0);
    assign w_stall    = w_exe_hold || w_hz;

    assign stall      = w_stall;
    assign exe_hold   = w_exe_hold;
    // A held op must not be replaced by a NOP; Decode stays frozen instead.
    assign exe_bubble = w_hz && !w_exe_hold;
    assign mem_bubble = w_exe_hold;
    assign busy       = (r_state == S_MC_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (exe_mc_start) begin
                        r_state <= S_MC_BUSY;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                S_MC_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int AW   = 6;
    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] dec_rs1, dec_rs2, exe_rd, mem_rd;
    logic          dec_uses_rs1, dec_uses_rs2, dec_is_branch;
    logic          exe_reg_we, exe_is_load, exe_mc_start;
    logic          mem_reg_we, mem_is_load;
    logic          stall, exe_bubble, exe_hold, mem_bubble, busy;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an op is "in flight" for LAT cycles counted by age.
    bit m_in_op = 1'b0;
    int m_age   = 0;
    int m_cnt   = 0;

    hazard_stall_ctrl #(.ADDR_W(AW), .MC_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_is_branch(dec_is_branch),
        .exe_rd(exe_rd), .exe_reg_we(exe_reg_we), .exe_is_load(exe_is_load),
        .exe_mc_start(exe_mc_start),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
        .stall(stall), .exe_bubble(exe_bubble), .exe_hold(exe_hold),
        .mem_bubble(mem_bubble), .busy(busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic bit f_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && (a != 0);
    endfunction

    function automatic bit f_hz();
        bit lu, br;
        lu = exe_is_load && exe_reg_we &&
             ((dec_uses_rs1 && f_match(dec_rs1, exe_rd)) ||
              (dec_uses_rs2 && f_match(dec_rs2, exe_rd)));
        br = dec_is_branch && dec_uses_rs1 &&
             ((exe_reg_we && f_match(dec_rs1, exe_rd)) ||
              (mem_is_load && mem_reg_we && f_match(dec_rs1, mem_rd)));
        return lu || br;
    endfunction

    function automatic bit f_hold();
        if (m_in_op) return (m_age < LAT - 1);
        return exe_mc_start;
    endfunction

    function automatic int f_cnt();
`ifdef STALL_PERF_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        bit s;
        s = f_hold() || f_hz();
        @(posedge clk);
        if (reset) begin
            m_in_op = 1'b0;
            m_age   = 0;
            m_cnt   = 0;
        end else begin
            if (s && m_cnt < MAXC) m_cnt++;
            if (m_in_op) begin
                if (m_age == LAT - 1) m_in_op = 1'b0;
                else m_age++;
            end else if (exe_mc_start) begin
                m_in_op = 1'b1;
                m_age   = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        dec_rs1 = '0; dec_rs2 = '0; exe_rd = '0; mem_rd = '0;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_is_branch = 0;
        exe_reg_we = 0; exe_is_load = 0; exe_mc_start = 0;
        mem_reg_we = 0; mem_is_load = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        n_checks++; if (exe_bubble !== 1'b0) begin n_errors++; $display("FAIL reset_exe_bubble: got %0b expected 0", exe_bubble); end
        n_checks++; if (exe_hold !== 1'b0) begin n_errors++; $display("FAIL reset_exe_hold: got %0b expected 0", exe_hold); end
        n_checks++; if (mem_bubble !== 1'b0) begin n_errors++; $display("FAIL reset_mem_bubble: got %0b expected 0", mem_bubble); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (stall_count !== '0) begin n_errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        // lw r3 in EX, add r4,r3,r5 in Decode
        clear_inputs();
        exe_rd = 6'd3; exe_reg_we = 1; exe_is_load = 1;
        dec_rs1 = 6'd3; dec_rs2 = 6'd5; dec_uses_rs1 = 1; dec_uses_rs2 = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %0b expected 1", stall); end
        n_checks++; if (exe_bubble !== 1'b1) begin n_errors++; $display("FAIL lu_bubble: got %0b expected 1", exe_bubble); end
        tick();
        // load now in MEM, bubble in EX
        exe_rd = '0; exe_reg_we = 0; exe_is_load = 0;
        mem_rd = 6'd3; mem_reg_we = 1; mem_is_load = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_next_stall: got %0b expected 0", stall); end
        n_checks++; if (exe_bubble !== 1'b0) begin n_errors++; $display("FAIL lu_next_bubble: got %0b expected 0", exe_bubble); end
        // rs2 side alone
        clear_inputs();
        exe_rd = 6'd7; exe_reg_we = 1; exe_is_load = 1;
        dec_rs1 = 6'd1; dec_rs2 = 6'd7; dec_uses_rs1 = 1; dec_uses_rs2 = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_rs2_stall: got %0b expected 1", stall); end
        dec_uses_rs2 = 0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_rs2_unused: got %0b expected 0", stall); end
        tick();
    endtask

    task automatic test_r0();
        clear_inputs();
        exe_rd = '0; exe_reg_we = 1; exe_is_load = 1;
        dec_rs1 = '0; dec_rs2 = '0; dec_uses_rs1 = 1; dec_uses_rs2 = 1; dec_is_branch = 1;
        mem_rd = '0; mem_reg_we = 1; mem_is_load = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL r0_stall: got %0b expected 0", stall); end
        n_checks++; if (exe_bubble !== 1'b0) begin n_errors++; $display("FAIL r0_bubble: got %0b expected 0", exe_bubble); end
        tick();
    endtask

    task automatic test_branch();
        // beqz r2 with add r2 in EX: one stall cycle
        clear_inputs();
        dec_is_branch = 1; dec_uses_rs1 = 1; dec_rs1 = 6'd2;
        exe_rd = 6'd2; exe_reg_we = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL br_alu_c0: got %0b expected 1", stall); end
        tick();
        exe_rd = '0; exe_reg_we = 0;
        mem_rd = 6'd2; mem_reg_we = 1; mem_is_load = 0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL br_alu_c1: got %0b expected 0", stall); end
        tick();
        // beqz r2 with lw r2 in EX: two stall cycles
        clear_inputs();
        dec_is_branch = 1; dec_uses_rs1 = 1; dec_rs1 = 6'd2;
        exe_rd = 6'd2; exe_reg_we = 1; exe_is_load = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL br_ld_c0: got %0b expected 1", stall); end
        tick();
        exe_rd = '0; exe_reg_we = 0; exe_is_load = 0;
        mem_rd = 6'd2; mem_reg_we = 1; mem_is_load = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL br_ld_c1: got %0b expected 1", stall); end
        n_checks++; if (exe_bubble !== 1'b1) begin n_errors++; $display("FAIL br_ld_c1_bubble: got %0b expected 1", exe_bubble); end
        tick();
        mem_rd = '0; mem_reg_we = 0; mem_is_load = 0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL br_ld_c2: got %0b expected 0", stall); end
        tick();
    endtask

    task automatic test_multicycle();
        bit eh[4];
        bit eb[4];
        eh = '{1'b1, 1'b1, 1'b1, 1'b0};
        eb = '{1'b0, 1'b1, 1'b1, 1'b1};
        clear_inputs();
        exe_mc_start = 1;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                // load-use pattern present while the op is held
                exe_rd = 6'd4; exe_reg_we = 1; exe_is_load = 1;
                dec_rs1 = 6'd4; dec_uses_rs1 = 1;
            end else begin
                exe_is_load = 0; dec_uses_rs1 = 0;
            end
            #1;
            n_checks++; if (exe_hold !== eh[c]) begin n_errors++; $display("FAIL mc_hold c%0d: got %0b expected %0b", c, exe_hold, eh[c]); end
            n_checks++; if (busy !== eb[c]) begin n_errors++; $display("FAIL mc_busy c%0d: got %0b expected %0b", c, busy, eb[c]); end
            n_checks++; if (mem_bubble !== eh[c]) begin n_errors++; $display("FAIL mc_mem_bubble c%0d: got %0b expected %0b", c, mem_bubble, eh[c]); end
            n_checks++; if (exe_bubble !== 1'b0) begin n_errors++; $display("FAIL mc_exe_bubble c%0d: got %0b expected 0", c, exe_bubble); end
            n_checks++; if (stall !== eh[c]) begin n_errors++; $display("FAIL mc_stall c%0d: got %0b expected %0b", c, stall, eh[c]); end
            tick();
        end
        clear_inputs();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mc_done_busy: got %0b expected 0", busy); end
        n_checks++; if (exe_hold !== 1'b0) begin n_errors++; $display("FAIL mc_done_hold: got %0b expected 0", exe_hold); end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        exe_mc_start = 1;
        tick();
        reset = 1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rm_busy_before: got %0b expected 1", busy); end
        tick();
        reset = 0;
        exe_mc_start = 0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %0b expected 0", busy); end
        n_checks++; if (exe_hold !== 1'b0) begin n_errors++; $display("FAIL rm_hold: got %0b expected 0", exe_hold); end
        n_checks++; if (stall_count !== '0) begin n_errors++; $display("FAIL rm_count: got %0d expected 0", stall_count); end
        tick();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_sat;
`ifdef STALL_PERF_EN
        exp_sat = 4'd15;
`else
        exp_sat = 4'd0;
`endif
        reset = 1;
        clear_inputs();
        tick();
        reset = 0;
        exe_rd = 6'd9; exe_reg_we = 1; exe_is_load = 1;
        dec_rs2 = 6'd9; dec_uses_rs2 = 1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_checks++; if (stall_count !== exp_sat) begin n_errors++; $display("FAIL sat_count: got %0d expected %0d", stall_count, exp_sat); end
        for (int i = 0; i < 3; i++) tick();
        #1;
        n_checks++; if (stall_count !== exp_sat) begin n_errors++; $display("FAIL sat_hold: got %0d expected %0d", stall_count, exp_sat); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        bit e_hold, e_hz;
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            dec_rs1       = AW'($urandom_range(0, 3));
            dec_rs2       = AW'($urandom_range(0, 3));
            exe_rd        = AW'($urandom_range(0, 3));
            mem_rd        = AW'($urandom_range(0, 3));
            dec_uses_rs1  = 1'($urandom);
            dec_uses_rs2  = 1'($urandom);
            dec_is_branch = 1'($urandom);
            exe_reg_we    = 1'($urandom);
            exe_is_load   = 1'($urandom);
            exe_mc_start  = ($urandom_range(0, 4) == 0);
            mem_reg_we    = 1'($urandom);
            mem_is_load   = 1'($urandom);
            #1;
            e_hold = f_hold();
            e_hz   = f_hz();
            n_checks++; if (stall !== (e_hold || e_hz)) begin n_errors++; $display("FAIL rnd_stall i%0d: got %0b expected %0b", i, stall, e_hold || e_hz); end
            n_checks++; if (exe_bubble !== (e_hz && !e_hold)) begin n_errors++; $display("FAIL rnd_exe_bubble i%0d: got %0b expected %0b", i, exe_bubble, e_hz && !e_hold); end
            n_checks++; if (exe_hold !== e_hold) begin n_errors++; $display("FAIL rnd_exe_hold i%0d: got %0b expected %0b", i, exe_hold, e_hold); end
            n_checks++; if (mem_bubble !== e_hold) begin n_errors++; $display("FAIL rnd_mem_bubble i%0d: got %0b expected %0b", i, mem_bubble, e_hold); end
            n_checks++; if (busy !== m_in_op) begin n_errors++; $display("FAIL rnd_busy i%0d: got %0b expected %0b", i, busy, m_in_op); end
            n_checks++; if (stall_count !== CW'(f_cnt())) begin n_errors++; $display("FAIL rnd_count i%0d: got %0d expected %0d", i, stall_count, f_cnt()); end
            tick();
        end
        reset = 0;
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_r0();
        test_branch();
        test_multicycle();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
